lfsr_sample_collector: RTL and testbench

- Downstream consumer of the 8-bit LFSR number generator.
- On a start pulse, it runs the generator's request/busy handshake N times and collects N pseudo-random bytes.
- It accumulates sum, minimum, maximum and the count of odd samples, then pulses done with the results held stable.
- Sits between the LFSR stage and the display/statistics logic. It is the only agent driving the generator's request line.

---
 rtl/collector_pkg.sv | 9 +
 rtl/sample_stats_acc.sv | 39 +++
 rtl/lfsr_sample_collector.sv | 104 ++++++++++
 tb/tb_lfsr_sample_collector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collector_pkg.sv
// collector_pkg: shared constants for the LFSR sample collector
package collector_pkg;
    localparam int DATA_W = 8;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_WAIT_LOW = 3'd2;
    localparam logic [2:0] ST_RELEASE  = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;
endpackage

// File: rtl/sample_stats_acc.sv
// sample_stats_acc: running sum, min, max and odd count over captured samples
module sample_stats_acc
    import collector_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    cap,
    input  logic                    force_zero,
    input  logic [DATA_W-1:0]       data,
    output logic [DATA_W+CNT_W-1:0] sum,
    output logic [DATA_W-1:0]       min_val,
    output logic [DATA_W-1:0]       max_val,
    output logic [CNT_W-1:0]        odd_cnt
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum     <= '0;
            min_val <= '0;
            max_val <= '0;
            odd_cnt <= '0;
        end else if (clr) begin
            sum     <= '0;
            min_val <= '1;
            max_val <= '0;
            odd_cnt <= '0;
        end else if (force_zero) begin
            min_val <= '0;
            max_val <= '0;
        end else if (cap) begin
            sum     <= sum + (DATA_W+CNT_W)'(data);
            min_val <= data < min_val ? data : min_val;
            max_val <= data > max_val ? data : max_val;
            odd_cnt <= odd_cnt + CNT_W'(data[0]);
        end
    end
endmodule

// File: rtl/lfsr_sample_collector.sv
// lfsr_sample_collector: runs the LFSR request/busy handshake N times and
// accumulates sum/min/max/odd statistics of the returned bytes.
module lfsr_sample_collector
    import collector_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        n_samples,
    output logic                    lfsr_req,
    input  logic                    lfsr_busy,
    input  logic [DATA_W-1:0]       lfsr_data,
    output logic                    running,
    output logic                    done,
    output logic                    error,
    output logic [DATA_W+CNT_W-1:0] sum,
    output logic [DATA_W-1:0]       min_val,
    output logic [DATA_W-1:0]       max_val,
    output logic [CNT_W-1:0]        odd_cnt
);
    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] remaining;
    logic [TO_W-1:0]  wait_cnt;
    logic             no_samples;
    logic             accept, capture, expired;

    assign accept  = state == ST_IDLE && start;
    assign capture = state == ST_WAIT_LOW && !lfsr_busy;
    // the timeout only applies while the awaited busy edge has not arrived
    assign expired = wait_cnt == TO_LAST &&
                     ((state == ST_REQ && !lfsr_busy) || (state == ST_WAIT_LOW && lfsr_busy));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            wait_cnt   <= '0;
            no_samples <= 1'b0;
            lfsr_req   <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    remaining  <= n_samples;
                    no_samples <= n_samples == '0;
                    wait_cnt   <= '0;
                    error      <= 1'b0;
                    running    <= 1'b1;
                    lfsr_req   <= n_samples != '0;
                    state      <= n_samples == '0 ? ST_FINISH : ST_REQ;
                end
                ST_REQ, ST_WAIT_LOW: if (expired) begin
                    error    <= 1'b1;
                    lfsr_req <= 1'b0;
                    running  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= ST_IDLE;
                end else if (state == ST_REQ && lfsr_busy) begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT_LOW;
                end else if (capture) begin
                    remaining <= remaining - 1'b1;
                    lfsr_req  <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= ST_RELEASE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                ST_RELEASE: begin
                    lfsr_req <= remaining != '0;
                    state    <= remaining == '0 ? ST_FINISH : ST_REQ;
                end
                ST_FINISH: begin
                    done    <= 1'b1;
                    running <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sample_stats_acc #(.CNT_W(CNT_W)) u_stats (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept),
        .cap        (capture),
        .force_zero (state == ST_FINISH && no_samples),
        .data       (lfsr_data),
        .sum        (sum),
        .min_val    (min_val),
        .max_val    (max_val),
        .odd_cnt    (odd_cnt)
    );
endmodule

// File: tb/tb_lfsr_sample_collector.sv
// tb_lfsr_sample_collector: scoreboard bench with a behavioural LFSR generator
// and a sequence-level reference model of the collected statistics.
module tb_lfsr_sample_collector;
    typedef struct {
        logic [11:0] sum;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [3:0]  odd;
        int          n;
        int          start;
    } exp_t;

    logic        clk = 0, rst = 0, start = 0;
    logic [3:0]  n_samples = 0;
    logic        lfsr_req, running, done, error;
    logic [11:0] sum;
    logic [7:0]  min_val, max_val;
    logic [3:0]  odd_cnt;

    logic        gen_busy = 0, armed = 1, stall = 0;
    logic [7:0]  gen_num = 8'h01, seed_val = 8'h01;
    logic        seed_tog = 0, seed_seen = 0;

    int   cyc = 0, checks = 0, errors = 0;
    exp_t q[$];
    exp_t mon_e;

    lfsr_sample_collector dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_samples (n_samples),
        .lfsr_req  (lfsr_req),
        .lfsr_busy (gen_busy),
        .lfsr_data (gen_num),
        .running   (running),
        .done      (done),
        .error     (error),
        .sum       (sum),
        .min_val   (min_val),
        .max_val   (max_val),
        .odd_cnt   (odd_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] nxt(input logic [7:0] g);
        return {g[6:0], ^(g & 8'h9F)};
    endfunction

    // upstream generator: busy for one cycle per accepted request, re-arms after req low
    always @(posedge clk) begin
        if (seed_tog != seed_seen) begin
            seed_seen <= seed_tog;
            gen_num   <= seed_val;
        end
        if (gen_busy) begin
            gen_busy <= 0;
            gen_num  <= nxt(gen_num);
            armed    <= 0;
        end else if (lfsr_req && armed && !stall) begin
            gen_busy <= 1;
        end
        if (!lfsr_req) armed <= 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] g, input int n);
        exp_t e;
        e.sum = 0; e.mn = 8'hFF; e.mx = 0; e.odd = 0; e.n = n; e.start = 0;
        for (int i = 0; i < n; i++) begin
            g = nxt(g);
            e.sum += 12'(g);
            if (g < e.mn) e.mn = g;
            if (g > e.mx) e.mx = g;
            e.odd += 4'(g[0]);
        end
        if (n == 0) e.mn = 0;
        return e;
    endfunction

    always @(negedge clk) if (rst && done) begin
        if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
        end else begin
            mon_e = q.pop_front();
            chk("sum", 32'(sum), 32'(mon_e.sum));
            chk("min_val", 32'(min_val), 32'(mon_e.mn));
            chk("max_val", 32'(max_val), 32'(mon_e.mx));
            chk("odd_cnt", 32'(odd_cnt), 32'(mon_e.odd));
            chk("latency", cyc + 1 - mon_e.start, 4 * mon_e.n + 2);
        end
    end

    task automatic set_seed(input logic [7:0] s);
        @(negedge clk);
        seed_val = s;
        seed_tog = ~seed_tog;
        @(negedge clk);
    endtask

    task automatic launch(input int n, input bit expect_run);
        exp_t e;
        @(negedge clk);
        e = model(gen_num, n);
        start = 1;
        n_samples = 4'(n);
        @(posedge clk);
        #1 start = 0;
        e.start = cyc;
        if (expect_run) q.push_back(e);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = !running;
        end
        if (!ok) chk("run_timeout", 0, 1);
        @(negedge clk);
        chk("sb_drained", q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, 32'(lfsr_req), 0);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_sum"}, 32'(sum), 0);
        chk({tag, "_min"}, 32'(min_val), 0);
        chk({tag, "_max"}, 32'(max_val), 0);
        chk({tag, "_odd"}, 32'(odd_cnt), 0);
    endtask

    task automatic chk_seed1_result(input string tag);
        chk({tag, "_sum"}, 32'(sum), 32'h15);
        chk({tag, "_min"}, 32'(min_val), 32'h03);
        chk({tag, "_max"}, 32'(max_val), 32'h0C);
        chk({tag, "_odd"}, 32'(odd_cnt), 1);
    endtask

    initial begin
        logic [13:0] pat;
        int hi;
        bit got;
        bit ok;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1;

        set_seed(8'h01);
        launch(3, 1);
        pat = 0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            pat[j] = lfsr_req;
        end
        chk("req_pattern", 32'(pat), 32'h777);
        wait_done();
        chk_seed1_result("seed1");

        launch(0, 1);
        pat = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            pat[j] = lfsr_req;
        end
        chk("n0_req", 32'(pat), 0);
        wait_done();

        stall = 1;
        launch(2, 0);
        hi = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (error) got = 1;
            else if (lfsr_req) hi++;
        end
        chk("timeout_flag", 32'(got), 1);
        chk("timeout_req_cycles", hi, 16);
        chk("timeout_running", 32'(running), 0);
        stall = 0;
        repeat (3) @(negedge clk);
        chk("error_sticky", 32'(error), 1);
        launch(1, 1);
        chk("error_cleared", 32'(error), 0);
        wait_done();

        set_seed(8'h01);
        launch(3, 1);
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            start = (j % 3 == 1) || j == 12;
            n_samples = 4'd7;
        end
        start = 0;
        wait_done();
        chk_seed1_result("restart");
        chk("restart_idle", 32'(running), 0);

        launch(5, 1);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = gen_busy;
        end
        chk("busy_seen", 32'(ok), 1);
        @(posedge clk);
        #2 rst = 0;
        q.delete();
        #1 chk_zero("midreset");
        @(negedge clk);
        rst = 1;
        launch(1, 1);
        wait_done();

        set_seed(8'hFF);
        launch(15, 1);
        wait_done();

        for (int r = 0; r < 8; r++) begin
            set_seed(8'($urandom_range(1, 255)));
            launch(int'($urandom_range(0, 15)), 1);
            wait_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
